mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 16-bit pipelined processor; consumes the execute/memory pipeline register outputs (the *_xm signals).
- Performs data-memory loads and stores over a variable-latency request/acknowledge interface.
- Forwards store data from the instruction currently in writeback.
- Contains the memory/writeback pipeline register (the *_mw signals) that feeds the writeback stage.
- Raises mem_stall so the hazard unit freezes every earlier stage while an access is outstanding.

Parameters:
- TIMEOUT, 15, maximum cycles spent in BUSY waiting for dmem_ack before the access is force-completed with an error.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- hlt_xm, mem_read_xm, mem_write_xm, mem_to_reg_xm, reg_write_xm, pcs_xm  in  1 each  control bits from the execute/memory register.
- write_reg_xm  in  4  destination register.
- rt_xm  in  4  store source register number.
- next_pc_xm  in  16  PC+2, used by PCS.
- reg2_xm  in  16  store data before forwarding.
- alu_out_xm  in  16  ALU result / effective address.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  16  word-aligned address.
- dmem_wdata  out  16  store data.
- dmem_rdata  in  16  load data, valid with ack.
- dmem_ack  in  1  access complete; may arrive in the same cycle as the request or later.
- mem_stall  out  1  holds the earlier pipeline stages.
- mem_err  out  1  sticky timeout flag.
- hlt_mw, mem_to_reg_mw, reg_write_mw, pcs_mw  out  1 each  memory/writeback register control bits.
- write_reg_mw  out  4  destination register.
- mem_data_mw, alu_out_mw, next_pc_mw  out  16 each  writeback data candidates.

Behaviour:
- Reset values: every register is cleared on rst.
  - All *_mw outputs = 0, mem_err = 0, FSM = IDLE, wait counter = 0.
  - dmem_req = 0 and mem_stall = 0 in the reset cycle.
- Access: access = mem_read_xm | mem_write_xm. If both are set, the access is a store.
- Address: dmem_addr = {alu_out_xm[15:1], 1'b0}.
- Store forwarding:
  - Condition: mem_write_xm & reg_write_mw & (write_reg_mw == rt_xm) & (write_reg_mw != 0).
  - Forwarded value: pcs_mw ? next_pc_mw : (mem_to_reg_mw ? mem_data_mw : alu_out_mw).
  - Otherwise wdata = reg2_xm.
  - Forwarding is evaluated in the IDLE issue cycle only.
- FSM state IDLE:
  - access = 0: dmem_req = 0, mem_stall = 0; the memory/writeback register loads the *_xm controls, alu_out, next_pc and write_reg; mem_data_mw <= 0.
  - access = 1: combinationally dmem_req = 1, with dmem_we, dmem_addr and dmem_wdata driven as above.
    - Latch addr, we and wdata into hold registers.
    - dmem_ack = 1 in the same cycle: access completes (see Completion), mem_stall = 0, stay in IDLE (zero-wait).
    - dmem_ack = 0: mem_stall = 1, go to BUSY, counter <= 1.
- FSM state BUSY:
  - dmem_req = 1; dmem_we, dmem_addr and dmem_wdata come from the hold registers and stay stable.
  - mem_stall = 1 every cycle without ack.
  - dmem_ack = 1: complete the access, mem_stall = 0 in that cycle, go to IDLE.
  - No ack and counter == TIMEOUT: force completion with mem_data_mw <= 16'h0000, set mem_err, mem_stall = 0, go to IDLE.
  - Otherwise counter increments.
- Completion: the memory/writeback register loads the *_xm fields (held stable upstream by the stall); mem_data_mw <= dmem_rdata for a load, 0 for a store.
- Stalled cycles: the memory/writeback register loads a bubble (all control bits 0, data 0) so writeback does not retire twice.
  - Forwarding therefore relies on the wdata latched at issue.
- hlt_xm passes through to hlt_mw like any other control bit; halt does not block an outstanding access.
- mem_err clears only on rst.
- rst in BUSY: immediate return to IDLE; dmem_req = 0 from the reset cycle; the in-flight access is abandoned; a late dmem_ack in IDLE with no access is ignored.
- A dmem_ack arriving in IDLE with access = 0 has no effect.

Test Plan:
1. ALU op, no access: alu_out_xm = 16'h1234, reg_write_xm = 1, write_reg_xm = 5 -> next cycle alu_out_mw = 16'h1234, reg_write_mw = 1, write_reg_mw = 5; dmem_req and mem_stall stay 0.
2. Zero-wait load: mem_read_xm = 1, alu_out_xm = 16'h0043, ack in the same cycle with rdata = 16'hBEEF -> dmem_addr = 16'h0042, mem_stall = 0, next cycle mem_data_mw = 16'hBEEF.
3. 3-cycle-latency store: mem_write_xm = 1, reg2_xm = 16'h00AA, ack in the third cycle -> mem_stall = 1 for 2 cycles; dmem_addr and dmem_wdata stable; bubble in the memory/writeback register during the stall; single completion.
4. Store forwarding: previous instruction writes R3 = 16'h5555 via ALU (reg_write_mw = 1, write_reg_mw = 3); store with rt_xm = 3, reg2_xm = 16'h0000 -> dmem_wdata = 16'h5555.
   - Repeat with write_reg_mw = 0 -> no forwarding; dmem_wdata = reg2_xm.
5. Timeout: load, ack never asserted, TIMEOUT = 15 -> mem_stall is high for 15 cycles then drops; mem_data_mw = 0; mem_err = 1 and stays set.
6. Reset mid-access: rst pulsed in the second BUSY cycle -> the following cycle dmem_req = 0, all *_mw = 0, mem_err = 0; a late ack is then ignored.

Source files
------------

// File: rtl/mem_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage_if : data-memory request/acknowledge bus               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_stage_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage : memory stage with variable-latency data access and   |
// |             the memory/writeback pipeline register. Rev 1.0      |
// +------------------------------------------------------------------+
module mem_stage #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hlt_xm,
   input  logic        mem_read_xm,
   input  logic        mem_write_xm,
   input  logic        mem_to_reg_xm,
   input  logic        reg_write_xm,
   input  logic        pcs_xm,
   input  logic [3:0]  write_reg_xm,
   input  logic [3:0]  rt_xm,
   input  logic [15:0] next_pc_xm,
   input  logic [15:0] reg2_xm,
   input  logic [15:0] alu_out_xm,
   mem_stage_if.master dmem,
   output logic        mem_stall,
   output logic        mem_err,
   output logic        hlt_mw,
   output logic        mem_to_reg_mw,
   output logic        reg_write_mw,
   output logic        pcs_mw,
   output logic [3:0]  write_reg_mw,
   output logic [15:0] mem_data_mw,
   output logic [15:0] alu_out_mw,
   output logic [15:0] next_pc_mw
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              access, fwd_hit;
   logic [15:0]       fwd_data, issue_addr, issue_wdata;
   logic              hold_we;
   logic [15:0]       hold_addr, hold_wdata;
   logic              req, we, stall, mw_load, set_err;
   logic [15:0]       addr, wdata, mw_data;

   assign access      = mem_read_xm | mem_write_xm;
   assign fwd_hit     = mem_write_xm & reg_write_mw & (write_reg_mw == rt_xm)
                        & (write_reg_mw != 4'd0);
   assign fwd_data    = pcs_mw ? next_pc_mw : (mem_to_reg_mw ? mem_data_mw : alu_out_mw);
   assign issue_addr  = {alu_out_xm[15:1], 1'b0};
   assign issue_wdata = fwd_hit ? fwd_data : reg2_xm;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      req     = 1'b0;
      we      = mem_write_xm;
      addr    = issue_addr;
      wdata   = issue_wdata;
      stall   = 1'b0;
      mw_load = 1'b1;
      mw_data = 16'h0000;
      set_err = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               req = 1'b1;
               if (dmem.ack) begin
                  mw_data = mem_write_xm ? 16'h0000 : dmem.rdata;
               end else begin
                  stall   = 1'b1;
                  mw_load = 1'b0;
                  state_n = BUSY;
                  cnt_n   = CNT_W'(1);
               end
            end
         end
         BUSY: begin
            // Bus fields come from the issue-time copy so they stay stable.
            req   = 1'b1;
            we    = hold_we;
            addr  = hold_addr;
            wdata = hold_wdata;
            if (dmem.ack) begin
               mw_data = hold_we ? 16'h0000 : dmem.rdata;
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(TIMEOUT)) begin
               set_err = 1'b1;
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               stall   = 1'b1;
               mw_load = 1'b0;
               cnt_n   = cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      if (rst) begin
         req   = 1'b0;
         stall = 1'b0;
      end
   end

   assign dmem.req   = req;
   assign dmem.we    = we;
   assign dmem.addr  = addr;
   assign dmem.wdata = wdata;
   assign mem_stall  = stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         mem_err       <= 1'b0;
         hold_we       <= 1'b0;
         hold_addr     <= 16'h0000;
         hold_wdata    <= 16'h0000;
         hlt_mw        <= 1'b0;
         mem_to_reg_mw <= 1'b0;
         reg_write_mw  <= 1'b0;
         pcs_mw        <= 1'b0;
         write_reg_mw  <= 4'd0;
         mem_data_mw   <= 16'h0000;
         alu_out_mw    <= 16'h0000;
         next_pc_mw    <= 16'h0000;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (set_err) begin
            mem_err <= 1'b1;
         end
         if (state == IDLE && access) begin
            hold_we    <= mem_write_xm;
            hold_addr  <= issue_addr;
            hold_wdata <= issue_wdata;
         end
         // A stalled cycle loads a bubble so writeback never retires twice.
         if (mw_load) begin
            hlt_mw        <= hlt_xm;
            mem_to_reg_mw <= mem_to_reg_xm;
            reg_write_mw  <= reg_write_xm;
            pcs_mw        <= pcs_xm;
            write_reg_mw  <= write_reg_xm;
            mem_data_mw   <= mw_data;
            alu_out_mw    <= alu_out_xm;
            next_pc_mw    <= next_pc_xm;
         end else begin
            hlt_mw        <= 1'b0;
            mem_to_reg_mw <= 1'b0;
            reg_write_mw  <= 1'b0;
            pcs_mw        <= 1'b0;
            write_reg_mw  <= 4'd0;
            mem_data_mw   <= 16'h0000;
            alu_out_mw    <= 16'h0000;
            next_pc_mw    <= 16'h0000;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_stage : randomized bench with a transaction-level model   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_stage;
   localparam int TO    = 15;
   localparam int NEVER = 99;

   typedef struct {
      logic        hlt, rd, wr, m2r, rw, pcs;
      logic [3:0]  wreg, rt;
      logic [15:0] npc, reg2, alu;
   } instr_t;

   logic clk = 1'b0;
   logic rst;
   logic hlt_xm, mem_read_xm, mem_write_xm, mem_to_reg_xm, reg_write_xm, pcs_xm;
   logic [3:0]  write_reg_xm, rt_xm;
   logic [15:0] next_pc_xm, reg2_xm, alu_out_xm;
   logic mem_stall, mem_err, hlt_mw, mem_to_reg_mw, reg_write_mw, pcs_mw;
   logic [3:0]  write_reg_mw;
   logic [15:0] mem_data_mw, alu_out_mw, next_pc_mw;
   logic [55:0] mw_act;

   mem_stage_if dmem ();

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .hlt_xm(hlt_xm), .mem_read_xm(mem_read_xm), .mem_write_xm(mem_write_xm),
      .mem_to_reg_xm(mem_to_reg_xm), .reg_write_xm(reg_write_xm), .pcs_xm(pcs_xm),
      .write_reg_xm(write_reg_xm), .rt_xm(rt_xm), .next_pc_xm(next_pc_xm),
      .reg2_xm(reg2_xm), .alu_out_xm(alu_out_xm),
      .dmem(dmem.master),
      .mem_stall(mem_stall), .mem_err(mem_err),
      .hlt_mw(hlt_mw), .mem_to_reg_mw(mem_to_reg_mw), .reg_write_mw(reg_write_mw),
      .pcs_mw(pcs_mw), .write_reg_mw(write_reg_mw), .mem_data_mw(mem_data_mw),
      .alu_out_mw(alu_out_mw), .next_pc_mw(next_pc_mw)
   );

   always #5 clk = ~clk;

   assign mw_act = {hlt_mw, mem_to_reg_mw, reg_write_mw, pcs_mw, write_reg_mw,
                    mem_data_mw, alu_out_mw, next_pc_mw};

   int     checks = 0;
   int     errors = 0;
   instr_t exp_ins;
   logic [15:0] exp_md;
   logic   exp_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [55:0] pack_mw(input instr_t i, input logic [15:0] md);
      return {i.hlt, i.m2r, i.rw, i.pcs, i.wreg, md, i.alu, i.npc};
   endfunction

   function automatic instr_t mk(input logic rd, input logic wr, input logic rw,
                                 input logic m2r, input logic pcs, input logic [3:0] wreg,
                                 input logic [3:0] rt, input logic [15:0] alu,
                                 input logic [15:0] reg2);
      instr_t i;
      i.hlt = 1'b0; i.rd = rd; i.wr = wr; i.rw = rw; i.m2r = m2r; i.pcs = pcs;
      i.wreg = wreg; i.rt = rt; i.alu = alu; i.reg2 = reg2;
      i.npc = 16'($urandom);
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      int kind;
      kind  = $urandom_range(0, 3);
      i.hlt = ($urandom_range(0, 15) == 0);
      i.rd  = (kind == 1 || kind == 3);
      i.wr  = (kind == 2 || kind == 3);
      i.m2r = 1'($urandom);
      i.rw  = 1'($urandom);
      i.pcs = ($urandom_range(0, 3) == 0);
      i.wreg = 4'($urandom_range(0, 3));
      i.rt   = 4'($urandom_range(0, 3));
      i.npc  = 16'($urandom);
      i.reg2 = 16'($urandom);
      i.alu  = 16'($urandom);
      return i;
   endfunction

   task automatic apply(input instr_t i);
      hlt_xm = i.hlt; mem_read_xm = i.rd; mem_write_xm = i.wr;
      mem_to_reg_xm = i.m2r; reg_write_xm = i.rw; pcs_xm = i.pcs;
      write_reg_xm = i.wreg; rt_xm = i.rt; next_pc_xm = i.npc;
      reg2_xm = i.reg2; alu_out_xm = i.alu;
   endtask

   // One instruction; lat = cycle (issue = 0) in which ack arrives, NEVER for none.
   // An access stalls min(lat, TO) cycles and completes in the next one.
   task automatic run_instr(input instr_t ins, input int lat);
      logic        acc;
      int          nst;
      logic [15:0] rd, exp_wd, exp_addr, md;
      acc = ins.rd | ins.wr;
      nst = acc ? ((lat > TO) ? TO : lat) : 0;
      rd  = 16'($urandom);
      exp_addr = ins.alu & 16'hFFFE;
      if (ins.wr && exp_ins.rw && exp_ins.wreg == ins.rt && exp_ins.wreg != 4'd0)
         exp_wd = exp_ins.pcs ? exp_ins.npc : (exp_ins.m2r ? exp_md : exp_ins.alu);
      else
         exp_wd = ins.reg2;
      apply(ins);
      for (int k = 0; k <= nst; k++) begin
         dmem.ack   = acc ? (k == lat) : 1'($urandom);
         dmem.rdata = (k == lat) ? rd : 16'($urandom);
         #1;
         check("stall", mem_stall, acc && (k < nst));
         check("req", dmem.req, acc);
         if (acc) begin
            check("addr", dmem.addr, exp_addr);
            check("we", dmem.we, ins.wr);
            if (ins.wr) check("wdata", dmem.wdata, exp_wd);
         end
         @(negedge clk);
         if (k < nst) begin
            check("bubble", mw_act, 56'h0);
         end else begin
            md = (acc && !ins.wr && lat <= TO) ? rd : 16'h0000;
            exp_err = exp_err | (acc && lat > TO);
            check("mw", mw_act, pack_mw(ins, md));
            check("err", mem_err, exp_err);
            exp_ins = ins;
            exp_md  = md;
         end
      end
      dmem.ack = 1'b0;
   endtask

   initial begin
      instr_t i;
      int     lat, r;
      exp_ins = '{default: 0};
      exp_md  = 16'h0000;
      exp_err = 1'b0;
      rst = 1'b1;
      apply(mk(1, 0, 1, 1, 0, 4'd2, 4'd0, 16'h0100, 16'h0));
      dmem.ack = 1'b0;
      dmem.rdata = 16'h0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_req", dmem.req, 1'b0);
      check("rst_stall", mem_stall, 1'b0);
      check("rst_mw", mw_act, 56'h0);
      check("rst_err", mem_err, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      run_instr(mk(0, 0, 1, 0, 0, 4'd5, 4'd0, 16'h1234, 16'h0), 0);
      run_instr(mk(1, 0, 1, 1, 0, 4'd6, 4'd0, 16'h0043, 16'h0), 0);
      run_instr(mk(0, 1, 0, 0, 0, 4'd0, 4'd7, 16'h0200, 16'h00AA), 2);
      run_instr(mk(0, 0, 1, 0, 0, 4'd3, 4'd0, 16'h5555, 16'h0), 0);
      run_instr(mk(0, 1, 0, 0, 0, 4'd0, 4'd3, 16'h0300, 16'h0000), 1);
      run_instr(mk(0, 0, 1, 0, 0, 4'd0, 4'd0, 16'h7777, 16'h0), 0);
      run_instr(mk(0, 1, 0, 0, 0, 4'd0, 4'd0, 16'h0302, 16'h1111), 0);
      run_instr(mk(0, 1, 0, 0, 0, 4'd1, 4'd1, 16'h0400, 16'h2222), TO);
      run_instr(mk(1, 0, 1, 1, 0, 4'd4, 4'd0, 16'h0501, 16'h0), NEVER);

      for (int n = 0; n < 80; n++) begin
         i   = rand_instr();
         r   = $urandom_range(0, 19);
         lat = (r == 19) ? NEVER : (r % 5);
         run_instr(i, lat);
      end

      // Reset while the access sits in BUSY, then a stray late ack.
      apply(mk(1, 0, 1, 1, 0, 4'd2, 4'd0, 16'h0600, 16'h0));
      dmem.ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_req", dmem.req, 1'b0);
      check("midrst_stall", mem_stall, 1'b0);
      @(negedge clk);
      check("midrst_mw", mw_act, 56'h0);
      check("midrst_err", mem_err, 1'b0);
      rst = 1'b0;
      exp_err = 1'b0;
      i = mk(0, 0, 1, 0, 0, 4'd9, 4'd0, 16'h4321, 16'h0);
      apply(i);
      dmem.ack = 1'b1;
      dmem.rdata = 16'hDEAD;
      #1;
      check("late_req", dmem.req, 1'b0);
      check("late_stall", mem_stall, 1'b0);
      @(negedge clk);
      check("late_mw", mw_act, pack_mw(i, 16'h0000));
      dmem.ack = 1'b0;
      exp_ins = i;
      exp_md  = 16'h0000;
      run_instr(mk(1, 0, 1, 1, 0, 4'd8, 4'd0, 16'h0700, 16'h0), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
